npc_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RV32E NPC. Sequences fetch, decode (decoder + imm_extend), execute, memory and

---
 rtl/npc_sequencer.sv | 156 +++++++++++++++
 tb/tb_npc_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_sequencer.sv
// npc_sequencer -- multi-cycle control FSM for the RV32E NPC.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB over the
// shared datapath. Owns the PC and instruction registers, the IFU/LSU request
// handshakes and the register-file write strobe.
//
// Handshakes: a request (ifu_req / lsu_req) is a Moore decode of the state and
// stays high for every cycle spent in FETCH / MEM. The response (ifu_valid /
// lsu_ready) is accepted on any posedge where the request is high, including the
// first one (zero-wait memory). A response seen outside FETCH / MEM is ignored.
//
// Ports:
//   clk, rst_n          core clock; synchronous active-low reset
//   ifu_req             fetch request, address = pc
//   ifu_valid, ifu_inst fetch response and instruction word
//   inst                latched instruction (feeds decoder / imm_extend)
//   pc                  current PC
//   type_in             decoder type: R=0 I=1 S=2 B=3 U=4 J=5
//   is_load, is_store   decoder memory-op flags
//   halt_in             decoder ebreak flag
//   next_pc             datapath-computed next PC
//   lsu_req, lsu_ready  data memory request / response
//   rf_wen              register-file write enable
//   retire              one-cycle pulse per retired instruction
//   halted, err         core halted / halt was caused by a fault
//
// Configuration macro: NPC_SEQ_TIMEOUT_EN adds a FETCH/MEM wait counter that
// halts the core with err=1 after TIMEOUT_CYC cycles without a response.
module npc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_inst,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [2:0]  type_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        halt_in,
  input  logic [31:0] next_pc,
  output logic        lsu_req,
  input  logic        lsu_ready,
  output logic        rf_wen,
  output logic        retire,
  output logic        halted,
  output logic        err
);

  localparam logic [2:0] INST_S = 3'd2;
  localparam logic [2:0] INST_B = 3'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic   misaligned;
  logic   wait_expired;

  assign misaligned = (next_pc[1:0] != 2'b00);

`ifdef NPC_SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // wait_cnt holds the number of already-elapsed waiting cycles, so the
  // TIMEOUT_CYC-th waiting cycle is the one where it equals TIMEOUT_CYC-1.
  assign wait_expired = (wait_cnt == WAIT_LAST) &&
                        ((state_q == FETCH && !ifu_valid) ||
                         (state_q == MEM   && !lsu_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (state_q == FETCH || state_q == MEM) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = ^TIMEOUT_CYC;
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc      <= RESET_PC;
      inst    <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && ifu_valid) begin
        inst <= ifu_inst;
      end
      if (state_q == WB) begin
        if (misaligned) begin
          err <= 1'b1;
        end else begin
          pc <= next_pc;
        end
      end
      if (wait_expired) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    rf_wen  = 1'b0;
    retire  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        ifu_req = 1'b1;
        if (ifu_valid)         state_d = DECODE;
        else if (wait_expired) state_d = HALT;
      end
      DECODE: state_d = halt_in ? HALT : EXEC;
      // load & store together takes the load path, which is the same MEM state.
      EXEC:   state_d = (is_load || is_store) ? MEM : WB;
      MEM: begin
        lsu_req = 1'b1;
        if (lsu_ready)         state_d = WB;
        else if (wait_expired) state_d = HALT;
      end
      WB: begin
        retire  = 1'b1;
        // A misaligned target faults the instruction: no architectural write.
        rf_wen  = !misaligned && (type_in != INST_S) && (type_in != INST_B);
        state_d = misaligned ? HALT : FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_npc_sequencer.sv
// Directed bench for npc_sequencer: walks ALU, load, store, branch, fault and
// ebreak instructions through the FSM and checks the strobes cycle by cycle.
module tb_npc_sequencer;

  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;

  logic        clk;
  logic        rst_n;
  logic        ifu_req;
  logic        ifu_valid;
  logic [31:0] ifu_inst;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [2:0]  type_in;
  logic        is_load;
  logic        is_store;
  logic        halt_in;
  logic [31:0] next_pc;
  logic        lsu_req;
  logic        lsu_ready;
  logic        rf_wen;
  logic        retire;
  logic        halted;
  logic        err;

  int passed;
  int total;

  npc_sequencer #(.RESET_PC(32'h8000_0000), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_valid(ifu_valid), .ifu_inst(ifu_inst),
    .inst(inst), .pc(pc),
    .type_in(type_in), .is_load(is_load), .is_store(is_store), .halt_in(halt_in),
    .next_pc(next_pc),
    .lsu_req(lsu_req), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .retire(retire), .halted(halted), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {ifu_req, lsu_req, rf_wen, retire, halted, err}
  task automatic chk_strobes(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, ifu_req, lsu_req, rf_wen, retire, halted, err}, {26'd0, exp});
  endtask

  task automatic set_inst(input logic [2:0] t, input logic ld, input logic st,
                          input logic hlt, input logic [31:0] npc);
    type_in  = t;
    is_load  = ld;
    is_store = st;
    halt_in  = hlt;
    next_pc  = npc;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    ifu_valid = 1'b0;
    ifu_inst  = 32'h0;
    lsu_ready = 1'b0;
    set_inst(T_I, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset held for three cycles
    step();
    step();
    step();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk_strobes("rst_strobes", 6'b000000);

    // Release: IDLE for one cycle, then FETCH
    rst_n = 1'b1;
    step();
    chk_strobes("idle_strobes", 6'b100000);

    // ADDI x1,x0,5 with zero-wait fetch
    ifu_valid = 1'b1;
    ifu_inst  = 32'h0050_0093;
    set_inst(T_I, 1'b0, 1'b0, 1'b0, 32'h8000_0004);
    step();                                   // DECODE
    ifu_valid = 1'b0;
    chk("addi_inst", inst, 32'h0050_0093);
    chk_strobes("addi_dec", 6'b000000);
    step();                                   // EXEC
    chk_strobes("addi_exec", 6'b000000);
    step();                                   // WB (4th cycle)
    chk_strobes("addi_wb", 6'b001100);
    chk("addi_wb_pc", pc, 32'h8000_0000);
    step();                                   // FETCH
    chk("addi_pc", pc, 32'h8000_0004);
    chk_strobes("addi_next", 6'b100000);

    // LW x2,0(x1): 3 fetch cycles, 2 memory cycles
    ifu_inst = 32'h0000_a103;
    set_inst(T_I, 1'b1, 1'b0, 1'b0, 32'h8000_0008);
    step();
    chk_strobes("lw_f2", 6'b100000);
    step();
    chk_strobes("lw_f3", 6'b100000);
    ifu_valid = 1'b1;
    step();                                   // DECODE
    ifu_valid = 1'b0;
    chk("lw_inst", inst, 32'h0000_a103);
    step();                                   // EXEC, stray fetch response
    ifu_valid = 1'b1;
    ifu_inst  = 32'hdead_beef;
    chk_strobes("lw_exec", 6'b000000);
    step();                                   // MEM 1
    ifu_valid = 1'b0;
    chk("lw_inst_kept", inst, 32'h0000_a103);
    chk_strobes("lw_m1", 6'b010000);
    step();                                   // MEM 2
    chk_strobes("lw_m2", 6'b010000);
    lsu_ready = 1'b1;
    step();                                   // WB (cycle 8 = 3+2+3)
    lsu_ready = 1'b0;
    chk_strobes("lw_wb", 6'b001100);
    step();
    chk("lw_pc", pc, 32'h8000_0008);

    // SW: store, rf_wen stays low
    ifu_valid = 1'b1;
    ifu_inst  = 32'h0020_a023;
    set_inst(T_S, 1'b0, 1'b1, 1'b0, 32'h8000_000c);
    step();                                   // DECODE
    ifu_valid = 1'b0;
    step();                                   // EXEC
    step();                                   // MEM
    chk_strobes("sw_mem", 6'b010000);
    lsu_ready = 1'b1;
    step();                                   // WB
    lsu_ready = 1'b0;
    chk_strobes("sw_wb", 6'b000100);
    step();
    chk("sw_pc", pc, 32'h8000_000c);

    // BEQ taken to 0x8000_0100
    ifu_valid = 1'b1;
    ifu_inst  = 32'h0e00_0a63;
    set_inst(T_B, 1'b0, 1'b0, 1'b0, 32'h8000_0100);
    step();
    ifu_valid = 1'b0;
    step();
    step();                                   // WB
    chk_strobes("beq_wb", 6'b000100);
    step();
    chk("beq_pc", pc, 32'h8000_0100);

    // Reset in the middle of a stalled fetch
    step();
    chk_strobes("midrst_pre", 6'b100000);
    rst_n = 1'b0;
    step();
    chk_strobes("midrst_req", 6'b000000);
    chk("midrst_pc", pc, 32'h8000_0000);
    rst_n = 1'b1;
    step();                                   // FETCH

    // is_load and is_store together take the load path
    ifu_valid = 1'b1;
    ifu_inst  = 32'h0000_2183;
    set_inst(T_I, 1'b1, 1'b1, 1'b0, 32'h8000_0004);
    step();
    ifu_valid = 1'b0;
    step();
    step();                                   // MEM
    chk_strobes("ldst_mem", 6'b010000);
    lsu_ready = 1'b1;
    step();
    lsu_ready = 1'b0;
    chk_strobes("ldst_wb", 6'b001100);
    step();
    chk("ldst_pc", pc, 32'h8000_0004);

    // Misaligned next_pc faults into HALT
    ifu_valid = 1'b1;
    ifu_inst  = 32'h0020_0093;
    set_inst(T_I, 1'b0, 1'b0, 1'b0, 32'h8000_0102);
    step();
    ifu_valid = 1'b0;
    step();
    step();                                   // WB
    chk_strobes("mis_wb", 6'b000100);
    step();                                   // HALT
    chk_strobes("mis_halt", 6'b000011);
    chk("mis_pc", pc, 32'h8000_0004);
    ifu_valid = 1'b1;
    lsu_ready = 1'b1;
    step();
    chk_strobes("mis_stay", 6'b000011);
    ifu_valid = 1'b0;
    lsu_ready = 1'b0;

    // ebreak halts without err
    rst_n = 1'b0;
    step();
    chk_strobes("eb_rst", 6'b000000);
    rst_n = 1'b1;
    step();                                   // FETCH
    ifu_valid = 1'b1;
    ifu_inst  = 32'h0010_0073;
    set_inst(T_I, 1'b0, 1'b0, 1'b1, 32'h8000_0004);
    step();                                   // DECODE
    ifu_valid = 1'b0;
    chk_strobes("eb_dec", 6'b000000);
    step();                                   // HALT
    chk_strobes("eb_halt", 6'b000010);
    chk("eb_pc", pc, 32'h8000_0000);

`ifdef NPC_SEQ_TIMEOUT_EN
    // Fetch never answers: HALT with err after the 16th waiting cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_inst(T_I, 1'b0, 1'b0, 1'b0, 32'h8000_0004);
    step();                                   // FETCH wait cycle 1
    for (int i = 2; i <= 16; i++) begin
      step();
    end
    chk_strobes("to_last_wait", 6'b100000);
    step();
    chk_strobes("to_halt", 6'b000011);
`endif

    // report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
